// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sharing of one pipelined multiplier with credit-limited issue
module mul_share_arbiter #(
    parameter int NREQ       = 4,
    parameter int MUL_LAT    = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int IDW        = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    input  logic [31:0]          mul_p,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_p,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    // wide enough to hold fifo occupancy plus every tracker stage without overflow
    localparam int OW = $clog2(FIFO_DEPTH + MUL_LAT + 2) + 1;
    localparam logic [OW-1:0]  DEPTH_C = OW'(FIFO_DEPTH);
    localparam logic [IDW:0]   NREQ_C  = (IDW + 1)'(NREQ);

    // arbitration state and operand registers
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [15:0]     mul_a_q, mul_a_d;
    logic [15:0]     mul_b_q, mul_b_d;

    // requester-id tracker aligned with the multiplier pipeline
    logic [MUL_LAT:0] trk_vld_q;
    logic [IDW-1:0]   trk_id_q [MUL_LAT+1];

    // result fifo
    logic [31:0]     mem_p  [FIFO_DEPTH];
    logic [IDW-1:0]  mem_id [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [OW-1:0]   inflight;
    logic [OW-1:0]   occupancy;
    logic            issue_ok;
    logic            found;
    logic            issue;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW:0]    cand;
    logic            push;
    logic            pop;

    // count operations still travelling through the multiplier
    always_comb begin
        inflight = '0;
        for (int s = 0; s <= MUL_LAT; s++) begin
            inflight = inflight + OW'(trk_vld_q[s]);
        end
    end

    // every issued op owns a fifo slot until it is popped, so the pipeline never needs to stall
    always_comb begin
        occupancy = OW'(count_q) + inflight;
        issue_ok  = (occupancy < DEPTH_C);
    end

    // round-robin search starting one past the last winner
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDW + 1)'(k);
            if (cand >= NREQ_C) begin
                cand = cand - NREQ_C;
            end
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[IDW-1:0];
            end
        end
        issue     = found && issue_ok && !rst;
        req_ready = issue ? (NREQ'(1) << gnt_idx) : '0;
    end

    // next operands and arbitration pointer; idle cycles feed zeros to the multiplier
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        mul_a_d  = '0;
        mul_b_d  = '0;
        if (issue) begin
            rr_ptr_d = gnt_idx;
            mul_a_d  = req_a[gnt_idx*16 +: 16];
            mul_b_d  = req_b[gnt_idx*16 +: 16];
        end
    end

    // fifo pointer and occupancy bookkeeping
    always_comb begin
        push     = trk_vld_q[MUL_LAT];
        pop      = rsp_valid && rsp_ready;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= IDW'(NREQ - 1);
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            trk_vld_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int s = 0; s <= MUL_LAT; s++) begin
                trk_id_q[s] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            trk_vld_q   <= {trk_vld_q[MUL_LAT-1:0], issue};
            trk_id_q[0] <= gnt_idx;
            for (int s = 1; s <= MUL_LAT; s++) begin
                trk_id_q[s] <= trk_id_q[s-1];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // capture the product whose id reaches the end of the tracker
    always_ff @(posedge clk) begin
        if (push) begin
            mem_p[wr_ptr_q]  <= mul_p;
            mem_id[wr_ptr_q] <= trk_id_q[MUL_LAT];
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = (count_q != '0);
    assign rsp_p     = rsp_valid ? mem_p[rd_ptr_q] : '0;
    assign rsp_id    = rsp_valid ? mem_id[rd_ptr_q] : '0;
    assign busy      = (inflight != '0) || (count_q != '0);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - randomized self-checking bench for mul_share_arbiter
`timescale 1ns/1ps
module tb_mul_share_arbiter;

    localparam int NREQ       = 4;
    localparam int MUL_LAT    = 5;
    localparam int FIFO_DEPTH = 8;
    localparam int IDW        = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [16*NREQ-1:0]  req_a = '0;
    logic [16*NREQ-1:0]  req_b = '0;
    logic [NREQ-1:0]     req_ready;
    logic [15:0]         mul_a;
    logic [15:0]         mul_b;
    logic [31:0]         mul_p;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [31:0]         rsp_p;
    logic [IDW-1:0]      rsp_id;
    logic                busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mul_share_arbiter #(
        .NREQ(NREQ), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH), .IDW(IDW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p), .rsp_id(rsp_id),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // multiplier: product of the operands seen in cycle c appears in cycle c+MUL_LAT
    logic [31:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) mpipe[i] <= '0;
        end else begin
            mpipe[0] <= {16'b0, mul_a} * {16'b0, mul_b};
            for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_p = mpipe[MUL_LAT-1];

    // reference model: list of issued-but-unpopped operations in issue order
    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    p;
        int             rdy;
    } exp_t;
    exp_t sq[$];
    int   last_grant = NREQ - 1;

    always @(negedge clk) begin
        int g;
        logic [NREQ-1:0] exp_rdy;
        logic exp_v;
        exp_t e;
        if (rst) begin
            sq.delete();
            last_grant = NREQ - 1;
        end else begin
            g = -1;
            if (sq.size() < FIFO_DEPTH) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (last_grant + k) % NREQ;
                    if (g < 0 && req_valid[c]) g = c;
                end
            end
            exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
            total++;
            if (req_ready !== exp_rdy) begin
                bad++;
                $display("FAIL sb_grant cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
            end
            exp_v = (sq.size() > 0) && (sq[0].rdy <= cyc);
            total++;
            if (rsp_valid !== exp_v) begin
                bad++;
                $display("FAIL sb_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_v);
            end
            if (exp_v) begin
                total++;
                if (rsp_p !== sq[0].p || rsp_id !== sq[0].id) begin
                    bad++;
                    $display("FAIL sb_rsp_data cyc=%0d got=%h/%0d exp=%h/%0d",
                             cyc, rsp_p, rsp_id, sq[0].p, sq[0].id);
                end
            end
            total++;
            if (busy !== (sq.size() != 0)) begin
                bad++;
                $display("FAIL sb_busy cyc=%0d got=%b exp=%b", cyc, busy, sq.size() != 0);
            end
            if (exp_v && rsp_ready) void'(sq.pop_front());
            if (g >= 0) begin
                e.id  = IDW'(g);
                e.p   = {16'b0, req_a[16*g +: 16]} * {16'b0, req_b[16*g +: 16]};
                e.rdy = cyc + MUL_LAT + 2;
                sq.push_back(e);
                last_grant = g;
            end
        end
    end

    // a push into a full fifo must never happen
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (dut.push && (dut.count_q == FIFO_DEPTH)) begin
                bad++;
                $display("FAIL fifo_overflow cyc=%0d count=%0d limit=%0d", cyc, dut.count_q, FIFO_DEPTH - 1);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        next_cycle();
        rst = 1'b1;
        req_valid = '0;
        repeat (n) next_cycle();
        rst = 1'b0;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) set_op(i, 16'($urandom), 16'($urandom));
    endtask

    task automatic test_reset();
        next_cycle();
        rst = 1'b1;
        req_valid = '1;
        rand_ops();
        next_cycle();
        @(negedge clk);
        total++;
        if ({req_ready, mul_a, mul_b, rsp_valid, busy} !== '0) begin
            bad++;
            $display("FAIL reset_hold got=%b/%h/%h/%b/%b exp=0", req_ready, mul_a, mul_b, rsp_valid, busy);
        end
        next_cycle();
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        total++;
        if ({req_ready, mul_a, mul_b, rsp_valid, busy} !== '0) begin
            bad++;
            $display("FAIL reset_release got=%b/%h/%h/%b/%b exp=0", req_ready, mul_a, mul_b, rsp_valid, busy);
        end
    endtask

    task automatic test_single();
        int t0;
        int lat;
        rsp_ready = 1'b1;
        next_cycle();
        set_op(2, 16'd3, 16'd5);
        req_valid = 4'b0100;
        t0 = cyc;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL single_grant got=%b exp=0100", req_ready);
        end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        total++;
        if (mul_a !== 16'd3 || mul_b !== 16'd5) begin
            bad++;
            $display("FAIL single_operands got=%h/%h exp=0003/0005", mul_a, mul_b);
        end
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (lat != 7 || rsp_p !== 32'd15 || rsp_id !== 2'd2) begin
            bad++;
            $display("FAIL single_rsp lat=%0d p=%0d id=%0d exp lat=7 p=15 id=2", lat, rsp_p, rsp_id);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL single_busy_after got=%b exp=0", busy);
        end
    endtask

    task automatic test_round_robin();
        int got;
        logic [31:0] ep;
        do_reset(1);
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, 16'(i + 1), 16'hFFFF);
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (req_ready !== (4'b0001 << (k % 4))) begin
                bad++;
                $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, 4'b0001 << (k % 4));
            end
            next_cycle();
        end
        req_valid = '0;
        got = 0;
        for (int k = 0; k < 30 && got < 5; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ep = 32'((got % 4) + 1) * 32'hFFFF;
                total++;
                if (rsp_id !== IDW'(got % 4) || rsp_p !== ep) begin
                    bad++;
                    $display("FAIL rr_rsp n=%0d got=%0d/%h exp=%0d/%h", got, rsp_id, rsp_p, got % 4, ep);
                end
                got++;
            end
        end
        total++;
        if (got != 5) begin
            bad++;
            $display("FAIL rr_count got=%0d exp=5", got);
        end
    endtask

    task automatic test_back_pressure();
        int n;
        int pops;
        do_reset(1);
        rsp_ready = 1'b0;
        rand_ops();
        req_valid = '1;
        n = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) n++;
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (n != 8 || req_ready !== '0) begin
            bad++;
            $display("FAIL bp_credit issues=%0d ready=%b exp 8/0000", n, req_ready);
        end
        next_cycle();
        rsp_ready = 1'b1;
        pops = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 0) begin
                total++;
                if (req_ready !== '0 || rsp_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_first_pop ready=%b valid=%b exp 0000/1", req_ready, rsp_valid);
                end
            end
            if (k == 1) begin
                total++;
                if (req_ready !== 4'b0001) begin
                    bad++;
                    $display("FAIL bp_resume got=%b exp=0001", req_ready);
                end
            end
            if (rsp_valid) pops++;
            next_cycle();
            if (k == 1) req_valid = '0;
        end
        total++;
        if (pops != 9) begin
            bad++;
            $display("FAIL bp_drain pops=%0d exp=9", pops);
        end
    endtask

    task automatic test_extremes();
        logic [31:0] ps [2];
        logic [IDW-1:0] ids [2];
        int got;
        rsp_ready = 1'b1;
        next_cycle();
        set_op(0, 16'hFFFF, 16'hFFFF);
        req_valid = 4'b0001;
        next_cycle();
        set_op(1, 16'h0000, 16'h1234);
        req_valid = 4'b0010;
        next_cycle();
        req_valid = '0;
        got = 0;
        for (int k = 0; k < 20 && got < 2; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ps[got]  = rsp_p;
                ids[got] = rsp_id;
                got++;
            end
        end
        total++;
        if (got != 2 || ps[0] !== 32'hFFFE0001 || ids[0] !== 2'd0) begin
            bad++;
            $display("FAIL ext_max n=%0d got=%h/%0d exp=fffe0001/0", got, ps[0], ids[0]);
        end
        total++;
        if (got != 2 || ps[1] !== 32'h0 || ids[1] !== 2'd1) begin
            bad++;
            $display("FAIL ext_zero n=%0d got=%h/%0d exp=00000000/1", got, ps[1], ids[1]);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset(1);
        rsp_ready = 1'b1;
        rand_ops();
        req_valid = '1;
        repeat (3) begin
            @(negedge clk);
            next_cycle();
        end
        req_valid = '0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            total++;
            if ({rsp_valid, busy, req_ready, mul_a, mul_b, rsp_p, rsp_id} !== '0) begin
                bad++;
                $display("FAIL midrst_quiet k=%0d valid=%b busy=%b a=%h p=%h exp all 0", k, rsp_valid, busy, mul_a, rsp_p);
            end
            next_cycle();
        end
        req_valid = '1;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL midrst_first_grant got=%b exp=0001", req_ready);
        end
        next_cycle();
        req_valid = '0;
    endtask

    task automatic test_back_to_back();
        int pops;
        do_reset(1);
        rsp_ready = 1'b1;
        pops = 0;
        for (int k = 0; k < 52; k++) begin
            rand_ops();
            req_valid = (k < 40) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            if (k < 40) begin
                total++;
                if (req_ready !== 4'b0010) begin
                    bad++;
                    $display("FAIL b2b_grant k=%0d got=%b exp=0010", k, req_ready);
                end
            end
            total++;
            if (dut.count_q > 1) begin
                bad++;
                $display("FAIL b2b_fifo_level k=%0d got=%0d exp<=1", k, dut.count_q);
            end
            if (rsp_valid) pops++;
            next_cycle();
        end
        req_valid = '0;
        total++;
        if (pops != 40) begin
            bad++;
            $display("FAIL b2b_count got=%0d exp=40", pops);
        end
    endtask

    task automatic test_random();
        do_reset(1);
        for (int k = 0; k < 400; k++) begin
            rand_ops();
            req_valid = NREQ'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            next_cycle();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (30) next_cycle();
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rand_drain busy=%b valid=%b exp 0/0", busy, rsp_valid);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_extremes();
        test_reset_midflight();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d limit=20000", cyc);
        $fatal(1);
    end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one pipelined 16x16 unsigned Wallace multiplier between NREQ requesters.
- Round-robin arbitration drives operands into the multiplier and tracks each operation's requester ID through the fixed multiplier latency.
- Completed products are buffered in a result FIFO with valid/ready output.
- Issue is credit-limited because the multiplier pipeline cannot stall, so no result is ever dropped.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MUL_LAT, 5, multiplier latency in cycles: operand on mul_a/mul_b sampled at edge k, product on mul_p after edge k+MUL_LAT.
- FIFO_DEPTH, 8, result FIFO entries (power of 2, at least 2).
- IDW, $clog2(NREQ), requester ID width.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_a  in  16*NREQ  operand A; requester i occupies [16i+15:16i].
- req_b  in  16*NREQ  operand B, same packing as req_a.
- req_ready  out  NREQ  one-hot grant; a handshake completes when req_valid[i] && req_ready[i].
- mul_a  out  16  registered operand A to the multiplier.
- mul_b  out  16  registered operand B to the multiplier.
- mul_p  in  32  product from the multiplier.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_p  out  32  product.
- rsp_id  out  IDW  index of the requester that issued this product.
- busy  out  1  high while any operation is in flight or the FIFO is non-empty.

Behaviour:
- Reset values:
  - req_ready=0, mul_a=0, mul_b=0, rsp_valid=0, busy=0.
  - rr_ptr=NREQ-1, so requester 0 wins first.
  - In-flight tracker and FIFO are cleared.
- Credits:
  - inflight = number of set bits in the tracker.
  - free = FIFO_DEPTH - fifo_count - inflight.
  - Issue is allowed only when free>0.
  - A FIFO pop in the same cycle does not add credit; credit frees on the following cycle.
- Arbitration (combinational):
  - If issue is allowed, grant the first i with req_valid[i]=1, searching from rr_ptr+1 upward and wrapping modulo NREQ.
  - req_ready = one-hot grant; all zero otherwise.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- On an issue at edge T:
  - mul_a/mul_b <= the granted operands.
  - rr_ptr <= granted index.
  - Tracker stage 0 <= {1, id}.
- With no issue:
  - mul_a/mul_b <= 0 and tracker stage 0 <= {0, x}.
  - rr_ptr holds.
- Tracker:
  - Shift register of MUL_LAT+1 stages of {valid, id}, shifting every cycle.
  - When the last stage is valid, mul_p and the stage's id are pushed into the FIFO at that edge.
- Latency:
  - Handshake in cycle T.
  - mul_a/mul_b valid in T+1.
  - mul_p valid in T+1+MUL_LAT.
  - rsp_valid=1 in T+2+MUL_LAT at the earliest (T+7 with defaults).
- Throughput: 1 issue per cycle while credits last.
- FIFO:
  - Push and pop in the same cycle are both performed and the count is unchanged.
  - Pop when rsp_valid && rsp_ready.
  - rsp_p/rsp_id show the head entry and stay stable while rsp_valid && !rsp_ready.
  - Order of results equals issue order.
- Boundaries:
  - A push into a full FIFO cannot happen by construction. The bench asserts this.
  - Pointer wrap at FIFO_DEPTH is silent.
  - With free=0, req_ready stays 0 even when requests are pending.
- Reset mid-operation:
  - In-flight operations and buffered results are discarded; no rsp_valid for them.
  - The multiplier must be reset on the same rst so that no stale mul_p is captured.
- busy = (inflight != 0) || (fifo_count != 0).

Test Plan:
- Single issue: req 2 presents A=3, B=5 in cycle 0, rsp_ready=1 -> req_ready=4'b0100 in cycle 0; rsp_valid in cycle 7 with rsp_p=15, rsp_id=2; busy low from cycle 8.
- Round-robin: all four valid every cycle with A=i+1, B=16'hFFFF -> grants cycle through 0,1,2,3,0; rsp_id follows the same sequence; rsp_p for id 3 = 32'h0003FFFC.
- Back-pressure: rsp_ready=0, all requesters continuously valid -> exactly 8 issues, then req_ready=0. After raising rsp_ready, all 8 results drain in order and issues resume one cycle after the first pop.
- Extremes: A=B=16'hFFFF -> rsp_p=32'hFFFE0001; A=0, B=16'h1234 -> rsp_p=0.
- Reset mid-flight: issue 3 operations, assert rst in the cycle after the third issue -> no rsp_valid afterward; all outputs 0; the next request after reset is granted to requester 0 first.
- Simultaneous push/pop: steady streaming with rsp_ready=1 and one requester -> fifo_count stays at most 1, one result per cycle, no lost or duplicated rsp_id.
